// File: rtl/iir_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | iir_pkg                                                            |
// | Shared widths, tap/state encodings and default coefficients for    |
// | the time-multiplexed biquad scheduler.                             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package iir_pkg;

  localparam int DATA_W = 18;
  localparam int COEF_W = 18;
  localparam int ACC_W  = 38;
  localparam int FRAC_W = 16;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int NTAP   = 5;

  typedef enum logic [2:0] {
    T_B0 = 3'd0,
    T_B1 = 3'd1,
    T_B2 = 3'd2,
    T_A1 = 3'd3,
    T_A2 = 3'd4
  } tap_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_WB   = 2'd2
  } state_e;

  localparam int B0_DEFAULT = 38663;
  localparam int B1_DEFAULT = 63776;
  localparam int B2_DEFAULT = 38663;
  localparam int A1_DEFAULT = 105388;
  localparam int A2_DEFAULT = 64739;

endpackage
`default_nettype wire

// File: rtl/iir_mac.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | iir_mac                                                            |
// | Shared 18x18 signed multiply with registered add/sub accumulate.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module iir_mac
  import iir_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     sub,
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [DATA_W-1:0] data,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  r_acc;

  assign w_prod = $signed({{(PROD_W-COEF_W){coef[COEF_W-1]}}, coef})
                * $signed({{(PROD_W-DATA_W){data[DATA_W-1]}}, data});
  assign w_prod_ext = $signed({{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= sub ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
    end
  end

  assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/iir_biquad_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | iir_biquad_sched                                                   |
// | Cascade of NSEC DF-I biquads sharing one MAC; five taps/section.   |
// | Optional macro IIR_SCHED_SAT_EN: saturate instead of wrap on scale.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module iir_biquad_sched
  import iir_pkg::*;
#(
  parameter int NSEC   = 2,
  parameter int B0_DEF = B0_DEFAULT,
  parameter int B1_DEF = B1_DEFAULT,
  parameter int B2_DEF = B2_DEFAULT,
  parameter int A1_DEF = A1_DEFAULT,
  parameter int A2_DEF = A2_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic signed [DATA_W-1:0] dout,
  output logic                     dout_valid,
  input  logic                     clr,
  input  logic                     cfg_we,
  input  logic [5:0]               cfg_addr,
  input  logic signed [COEF_W-1:0] cfg_wdata,
  output logic                     cfg_err,
  output logic                     busy
);

  localparam int NCOEF = NTAP * NSEC;
  localparam int SEC_W = (NSEC > 1) ? $clog2(NSEC) : 1;

  function automatic logic signed [COEF_W-1:0] def_coef(input int t);
    case (t)
      0:       return COEF_W'(B0_DEF);
      1:       return COEF_W'(B1_DEF);
      2:       return COEF_W'(B2_DEF);
      3:       return COEF_W'(A1_DEF);
      default: return COEF_W'(A2_DEF);
    endcase
  endfunction

  state_e                    r_state;
  tap_e                      r_tap;
  logic [SEC_W-1:0]          r_sec;
  logic signed [DATA_W-1:0]  r_xs;
  logic signed [COEF_W-1:0]  r_coef [NCOEF];
  logic signed [DATA_W-1:0]  r_x1 [NSEC];
  logic signed [DATA_W-1:0]  r_x2 [NSEC];
  logic signed [DATA_W-1:0]  r_y1 [NSEC];
  logic signed [DATA_W-1:0]  r_y2 [NSEC];

  logic                      w_accept;
  logic                      w_cfg_ok;
  logic                      w_clr_lines;
  logic [5:0]                w_cidx;
  logic signed [COEF_W-1:0]  w_coef;
  logic signed [DATA_W-1:0]  w_x1, w_x2, w_y1, w_y2, w_data;
  logic signed [ACC_W-1:0]   w_acc;
  logic signed [DATA_W-1:0]  w_y;

  assign din_ready   = (r_state == S_IDLE) && !clr;
  assign busy        = (r_state != S_IDLE);
  assign w_accept    = din_valid && din_ready;
  assign w_cfg_ok    = cfg_we && (r_state == S_IDLE) && (cfg_addr < 6'(NCOEF));
  assign w_clr_lines = clr && (r_state == S_IDLE);
  assign w_cidx      = 6'(r_sec) * 6'd5 + {3'b000, r_tap};

  always_comb begin
    w_x1   = '0;
    w_x2   = '0;
    w_y1   = '0;
    w_y2   = '0;
    w_coef = '0;
    for (int i = 0; i < NSEC; i++) begin
      if (r_sec == SEC_W'(i)) begin
        w_x1 = r_x1[i];
        w_x2 = r_x2[i];
        w_y1 = r_y1[i];
        w_y2 = r_y2[i];
      end
    end
    for (int i = 0; i < NCOEF; i++) begin
      if (w_cidx == 6'(i)) w_coef = r_coef[i];
    end
    case (r_tap)
      T_B0:    w_data = r_xs;
      T_B1:    w_data = w_x1;
      T_B2:    w_data = w_x2;
      T_A1:    w_data = w_y1;
      default: w_data = w_y2;
    endcase
  end

  // Accumulator is cleared in every non-MAC cycle, so each section starts from zero.
  iir_mac u_mac (
    .clk  (clk),
    .rst  (rst),
    .en   (r_state == S_MAC),
    .clr  (r_state != S_MAC),
    .sub  ((r_tap == T_A1) || (r_tap == T_A2)),
    .coef (w_coef),
    .data (w_data),
    .acc  (w_acc)
  );

`ifdef IIR_SCHED_SAT_EN
  logic signed [ACC_W-1:0] w_acc_sh;
  localparam logic signed [ACC_W-1:0] c_y_max = ACC_W'((1 <<< (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] c_y_min = -c_y_max - ACC_W'(1);

  assign w_acc_sh = w_acc >>> FRAC_W;

  always_comb begin
    if (w_acc_sh > c_y_max)      w_y = {1'b0, {(DATA_W-1){1'b1}}};
    else if (w_acc_sh < c_y_min) w_y = {1'b1, {(DATA_W-1){1'b0}}};
    else                         w_y = w_acc_sh[DATA_W-1:0];
  end
`else
  logic w_unused_acc;
  assign w_unused_acc = ^{w_acc[ACC_W-1:FRAC_W+DATA_W], w_acc[FRAC_W-1:0]};
  assign w_y = w_acc[FRAC_W+DATA_W-1:FRAC_W];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_tap      <= T_B0;
      r_sec      <= '0;
      r_xs       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      cfg_err    <= cfg_we && !w_cfg_ok;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_xs    <= din;
            r_sec   <= '0;
            r_tap   <= T_B0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          if (r_tap == T_A2) r_state <= S_WB;
          else               r_tap   <= tap_e'(r_tap + 3'd1);
        end
        S_WB: begin
          r_tap <= T_B0;
          if (r_sec != SEC_W'(NSEC-1)) begin
            r_xs    <= w_y;
            r_sec   <= r_sec + SEC_W'(1);
            r_state <= S_MAC;
          end else begin
            dout       <= w_y;
            dout_valid <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NSEC; i++) begin
        r_x1[i] <= '0;
        r_x2[i] <= '0;
        r_y1[i] <= '0;
        r_y2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NSEC; i++) begin
        if (w_clr_lines) begin
          r_x1[i] <= '0;
          r_x2[i] <= '0;
          r_y1[i] <= '0;
          r_y2[i] <= '0;
        end else if ((r_state == S_WB) && (r_sec == SEC_W'(i))) begin
          r_x2[i] <= r_x1[i];
          r_x1[i] <= r_xs;
          r_y2[i] <= r_y1[i];
          r_y1[i] <= w_y;
        end
      end
    end
  end

  // A write landing on the accept edge is visible to that sample's first tap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCOEF; i++) r_coef[i] <= def_coef(i % NTAP);
    end else if (w_cfg_ok) begin
      for (int i = 0; i < NCOEF; i++) begin
        if (cfg_addr == 6'(i)) r_coef[i] <= cfg_wdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iir_biquad_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_iir_biquad_sched                                                |
// | Scoreboard bench: arithmetic reference model vs. the scheduler.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_iir_biquad_sched;
  import iir_pkg::*;

  localparam int NSEC  = 2;
  localparam int NCOEF = 5 * NSEC;
  localparam int LAT   = 6 * NSEC;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [17:0] din = '0;
  logic               din_valid = 1'b0;
  logic               din_ready;
  logic signed [17:0] dout;
  logic               dout_valid;
  logic               clr = 1'b0;
  logic               cfg_we = 1'b0;
  logic [5:0]         cfg_addr = '0;
  logic signed [17:0] cfg_wdata = '0;
  logic               cfg_err;
  logic               busy;

  always #5 clk = ~clk;

  iir_biquad_sched #(.NSEC(NSEC)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .clr(clr), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err), .busy(busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state: coefficients, per-section history, expected outputs.
  int mc [NCOEF];
  int mx1 [NSEC], mx2 [NSEC], my1 [NSEC], my2 [NSEC];
  int idle_from = 0;
  int last_dout = 0;
  typedef struct { int y; int c; } exp_t;
  exp_t q [$];
  exp_t mon_e;

  function automatic int scale(input longint acc);
    longint s;
    logic [17:0] t;
    s = acc >>> 16;
`ifdef IIR_SCHED_SAT_EN
    if (s > 131071)  s = 131071;
    if (s < -131072) s = -131072;
    t = s[17:0];
`else
    t = s[17:0];
`endif
    return int'($signed(t));
  endfunction

  function automatic int model_run(input int x);
    longint acc;
    int v, y;
    v = x;
    for (int s = 0; s < NSEC; s++) begin
      acc = longint'(mc[s*5]) * v + longint'(mc[s*5+1]) * mx1[s] + longint'(mc[s*5+2]) * mx2[s]
          - longint'(mc[s*5+3]) * my1[s] - longint'(mc[s*5+4]) * my2[s];
      y = scale(acc);
      mx2[s] = mx1[s]; mx1[s] = v;
      my2[s] = my1[s]; my1[s] = y;
      v = y;
    end
    return v;
  endfunction

  task automatic clear_lines();
    for (int s = 0; s < NSEC; s++) begin
      mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
    end
  endtask

  task automatic reset_model();
    int defs [5];
    defs = '{B0_DEFAULT, B1_DEFAULT, B2_DEFAULT, A1_DEFAULT, A2_DEFAULT};
    for (int i = 0; i < NCOEF; i++) mc[i] = defs[i % 5];
    clear_lines();
    q.delete();
    idle_from = 0;
    last_dout = 0;
  endtask

  // Monitor: pops the scoreboard on every strobe and checks value and latency.
  always @(negedge clk) begin
    if (rst) begin
      if (dout_valid) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_dout_valid: actual dout %0d with no pending sample (cycle %0d)", dout, cyc);
        end else begin
          mon_e = q.pop_front();
          check("dout", longint'(dout), mon_e.y);
          check("latency_cycle", cyc, mon_e.c);
          last_dout = mon_e.y;
        end
      end else begin
        check("dout_hold", longint'(dout), last_dout);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    while (cyc < idle_from) tick();
  endtask

  task automatic send(input int x, input bit we, input int addr, input int data);
    int n;
    bit exp_err;
    n = 0;
    while (!din_ready && n < 200) begin
      tick();
      n++;
    end
    if (!din_ready) begin
      checks++;
      fails++;
      $display("FAIL ready_timeout: actual din_ready 0 required 1 within 200 cycles");
      return;
    end
    check("ready_not_early", cyc >= idle_from, 1'b1);
    din       = x[17:0];
    din_valid = 1'b1;
    cfg_we    = we;
    cfg_addr  = addr[5:0];
    cfg_wdata = data[17:0];
    exp_err   = we && !(addr < NCOEF);
    if (we && addr < NCOEF) mc[addr] = data;
    q.push_back('{model_run(x), cyc + 1 + LAT});
    idle_from = cyc + 1 + LAT;
    tick();
    din_valid = 1'b0;
    cfg_we    = 1'b0;
    if (we) check("cfg_err_on_accept", cfg_err, exp_err);
  endtask

  task automatic cfg_write(input int addr, input int data);
    bit idle, ok;
    idle = (cyc >= idle_from);
    ok   = idle && (addr < NCOEF);
    check("busy", busy, !idle);
    cfg_we    = 1'b1;
    cfg_addr  = addr[5:0];
    cfg_wdata = data[17:0];
    tick();
    cfg_we = 1'b0;
    check("cfg_err", cfg_err, !ok);
    if (ok) mc[addr] = data;
  endtask

  task automatic do_clr();
    wait_idle();
    clr       = 1'b1;
    din_valid = 1'b1;
    din       = 18'sd777;
    #1;
    check("clr_blocks_ready", din_ready, 1'b0);
    tick();
    clr       = 1'b0;
    din_valid = 1'b0;
    check("clr_no_accept_busy", busy, 1'b0);
    clear_lines();
  endtask

  task automatic stream(input int n);
    int got, last, budget;
    got = 0; last = 0; budget = 0;
    din_valid = 1'b1;
    din = 18'(int'($urandom_range(0, 2000)) - 1000);
    while (got < n && budget < 500) begin
      if (din_ready) begin
        if (got > 0) check("accept_spacing", cyc - last, LAT + 1);
        q.push_back('{model_run(int'(din)), cyc + 1 + LAT});
        idle_from = cyc + 1 + LAT;
        last = cyc;
        got++;
        tick();
        din = 18'(int'($urandom_range(0, 2000)) - 1000);
      end else begin
        tick();
      end
      budget++;
    end
    din_valid = 1'b0;
    if (got < n) begin
      checks++;
      fails++;
      $display("FAIL stream_timeout: actual %0d accepts required %0d", got, n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"}, longint'(dout), 0);
    check({tag, "_dout_valid"}, dout_valid, 1'b0);
    check({tag, "_cfg_err"}, cfg_err, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_din_ready"}, din_ready, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual simulation still running required completion");
    $fatal(1);
  end

  initial begin
    int r;
    reset_model();
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // Impulse through default coefficients
    send(1000, 0, 0, 0);
    send(0, 0, 0, 0);
    send(0, 0, 0, 0);

    // Back-to-back stream with din_valid held high
    stream(4);

    // Rejected writes: while busy and out of range while idle
    send(500, 0, 0, 0);
    cfg_write(3, 1234);
    wait_idle();
    cfg_write(NCOEF, 77);
    cfg_write(63, 5);
    do_clr();
    send(1000, 0, 0, 0);
    send(0, 0, 0, 0);

    // Clear wipes history: zero input then yields zero output
    wait_idle();
    do_clr();
    send(0, 0, 0, 0);

    // Full-scale coefficient and sample
    wait_idle();
    cfg_write(0, 131071);
    send(131071, 0, 0, 0);
    send(-131072, 1, 5, 65536);
    send(131071, 1, 2, -131072);

    // Asynchronous reset during the second section's MAC
    wait_idle();
    send(1000, 0, 0, 0);
    repeat (8) tick();
    rst = 1'b0;
    #1;
    reset_model();
    check_reset_outputs("midreset");
    tick(); tick();
    rst = 1'b1;
    check_reset_outputs("postreset");
    tick();
    send(1000, 0, 0, 0);
    send(0, 0, 0, 0);

    // Randomized traffic
    for (int k = 0; k < 30; k++) begin
      r = int'($urandom_range(0, 11));
      if (r < 3) begin
        wait_idle();
        cfg_write(int'($urandom_range(0, NCOEF + 2)), int'($urandom_range(0, 262143)) - 131072);
      end else if (r == 3) begin
        do_clr();
      end
      if (r == 4)
        send(int'($urandom_range(0, 262143)) - 131072, 1,
             int'($urandom_range(0, NCOEF + 1)), int'($urandom_range(0, 131071)) - 65536);
      else if (r < 8)
        send(int'($urandom_range(0, 262143)) - 131072, 0, 0, 0);
      else
        send(int'($urandom_range(0, 4000)) - 2000, 0, 0, 0);
      if (r == 9) cfg_write(int'($urandom_range(0, NCOEF - 1)), 1);
    end

    for (int n = 0; n < 300 && q.size() != 0; n++) tick();
    if (q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: actual %0d outputs outstanding required 0", q.size());
    end
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iir_biquad_sched.md
Name: iir_biquad_sched

Overview:
Time-multiplexed scheduler for a cascade of NSEC direct-form-I biquad sections. All sections share one 18x18 signed multiplier-accumulator. The block sequences the five MAC taps per section and holds the per-section delay lines and a runtime-writable coefficient bank. It sits between the sample source (valid/ready) and the downstream consumer (single-cycle dout_valid strobe).

Parameters:
NSEC, 2, number of cascaded biquad sections (1..8)
B0_DEF, 38663, reset value of b0 for every section (signed, Q2.16)
B1_DEF, 63776, reset value of b1
B2_DEF, 38663, reset value of b2
A1_DEF, 105388, reset value of a1
A2_DEF, 64739, reset value of a2

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
din  in  18  signed input sample
din_valid  in  1  input sample valid
din_ready  out  1  block idle, can accept a sample
dout  out  18  signed filtered sample, registered
dout_valid  out  1  one-cycle strobe, dout is new
clr  in  1  synchronous clear of all delay lines (honoured in IDLE only)
cfg_we  in  1  coefficient write strobe
cfg_addr  in  6  coefficient index = section*5 + tap (tap 0..4 = b0,b1,b2,a1,a2)
cfg_wdata  in  18  signed coefficient
cfg_err  out  1  one-cycle strobe: write rejected (busy or addr >= 5*NSEC)
busy  out  1  high outside IDLE

Behaviour:
- Reset (async, rst=0): state IDLE; dout=0, dout_valid=0, cfg_err=0, busy=0, din_ready=1. All x1/x2/y1/y2 are cleared. All coefficients load their *_DEF values. Reset mid-sequence abandons the sample with no dout_valid.
- din_ready = (state==IDLE) && !clr.
- States: IDLE -> MAC -> WB -> (MAC for next section | IDLE).
  - IDLE: on din_valid && din_ready, latch din as xs (section input), sec=0, tap=0, clear acc, go to MAC.
  - MAC: one tap per cycle, tap 0..4. Operands are b0*xs, b1*x1[sec], b2*x2[sec], a1*y1[sec], a2*y2[sec]. Taps 0-2 add the product to acc; taps 3-4 subtract it. After tap 4, go to WB.
  - WB: compute y = scale(acc). Update x2[sec]<=x1[sec], x1[sec]<=xs, y2[sec]<=y1[sec], y1[sec]<=y.
    - If sec<NSEC-1: xs<=y, sec++, clear acc, go to MAC.
    - Else: dout<=y, dout_valid=1 for the next cycle, go to IDLE.
- Widths: product 36-bit signed; acc 38-bit signed, so no overflow for 5 full-scale terms. scale() takes acc[33:16] (arithmetic shift by 16, truncate toward -inf), unless the optional feature below is enabled.
- Latency: accept edge to the edge that asserts dout_valid is 6*NSEC cycles. Minimum accept interval is 6*NSEC+1 cycles.
- clr in IDLE zeroes all delay lines at that edge. clr outside IDLE is ignored. clr takes priority over din_valid in the same cycle, so that sample is not accepted.
- cfg writes:
  - Accepted only when state==IDLE and addr < 5*NSEC.
  - A write in the same cycle as a sample accept is applied, and the new coefficient is used for that sample.
  - Otherwise the write is dropped and cfg_err pulses for one cycle.
- dout holds its value between strobes.

Optional Feature:
IIR_SCHED_SAT_EN:
- Defined: scale() saturates acc>>>16 to [-131072, 131071] before both writeback and dout.
- Undefined: plain truncation acc[33:16] with wrap-around.

Decomposition:
- Package iir_pkg holds:
  - DATA_W=18, COEF_W=18, ACC_W=38, FRAC_W=16
  - tap index enum (T_B0..T_A2)
  - state enum (S_IDLE, S_MAC, S_WB)
  - default coefficient constants
- One sub-module, iir_mac: registered multiply plus add/sub accumulate, with clr/sub controls. The scheduler owns the FSM, coefficient bank and delay-line arrays.

Test Plan:
- NSEC=1, defaults: impulse din=1000 then din=0 -> dout=589, then dout=25. dout_valid arrives 6 cycles after each accept.
- NSEC=2, din_valid held high with stream -> din_ready low for 12 cycles after each accept. Accepts are spaced 13 cycles apart and dout_valid pulses exactly once per accept.
- NSEC=1, cfg write addr 0 = 131071 in IDLE, then din=131071 -> dout=131071 with IIR_SCHED_SAT_EN, dout=-4 (0x3FFFC) without.
- cfg_we while busy, and cfg_addr=5*NSEC while idle -> cfg_err pulses each time. A subsequent impulse response matches the defaults.
- clr=1 with din_valid=1 in IDLE -> no accept. After an earlier impulse, the next din=0 gives dout=0 (delay lines cleared).
- rst pulsed during MAC of section 1 -> no dout_valid, dout=0, din_ready=1 after release. A repeat impulse reproduces the first test's outputs.
